// File: rtl/rggen_apb_arbiter.sv
// -----------------------------------------------------------------------------
// rggen_apb_arbiter
//
// Round-robin arbiter that lets MASTERS APB requesters share one APB completer
// port (typically the APB side of a generated register block).  Each granted
// transfer is sequenced through its own SETUP and ACCESS phases on the shared
// port. The completer's response goes back only to the granted requester.
//
// Ports
//   i_clk, i_rst                  clock, asynchronous active-high reset
//   i_psel/i_paddr/i_pwrite/      per-requester request side (packed vectors,
//   i_pwdata/i_pstrb              requester i at [i*W +: W])
//   o_pready/o_pslverr            per-requester completion and error (one-hot)
//   o_prdata                      completer read data, broadcast
//   o_psel/o_penable              shared-port control, registered
//   o_paddr/o_pwrite/o_pwdata/    shared-port address and data, muxed from the
//   o_pstrb                       granted requester
//   i_pready/i_prdata/i_pslverr   completer response
// -----------------------------------------------------------------------------
module rggen_apb_arbiter #(
    parameter int ADDRESS_WIDTH = 8,
    parameter int BUS_WIDTH     = 32,
    parameter int MASTERS       = 2
) (
    input  logic                              i_clk,
    input  logic                              i_rst,
    input  logic [MASTERS-1:0]                i_psel,
    input  logic [MASTERS*ADDRESS_WIDTH-1:0]  i_paddr,
    input  logic [MASTERS-1:0]                i_pwrite,
    input  logic [MASTERS*BUS_WIDTH-1:0]      i_pwdata,
    input  logic [MASTERS*BUS_WIDTH/8-1:0]    i_pstrb,
    output logic [MASTERS-1:0]                o_pready,
    output logic [BUS_WIDTH-1:0]              o_prdata,
    output logic [MASTERS-1:0]                o_pslverr,
    output logic                              o_psel,
    output logic                              o_penable,
    output logic [ADDRESS_WIDTH-1:0]          o_paddr,
    output logic                              o_pwrite,
    output logic [BUS_WIDTH-1:0]              o_pwdata,
    output logic [BUS_WIDTH/8-1:0]            o_pstrb,
    input  logic                              i_pready,
    input  logic [BUS_WIDTH-1:0]              i_prdata,
    input  logic                              i_pslverr
);
    localparam int IDX_W  = (MASTERS > 1) ? $clog2(MASTERS) : 1;
    localparam int STRB_W = BUS_WIDTH / 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t             r_state;
    logic               r_psel;
    logic               r_penable;
    logic [IDX_W-1:0]   r_grant;
    logic [IDX_W-1:0]   r_last;

    logic               w_any_req;
    logic [IDX_W-1:0]   w_winner;
    logic               w_complete;

    // Round-robin search starting at last+1.  Offsets are visited from the
    // farthest to the nearest so the nearest requesting index is written last
    // and therefore wins.  Offset MASTERS is the previous winner itself and
    // only wins when it is the sole requester.
    always_comb begin
        int idx;
        idx       = 0;
        w_any_req = |i_psel;
        w_winner  = r_last;
        for (int off = MASTERS; off >= 1; off--) begin
            idx = int'(r_last) + off;
            if (idx >= MASTERS) begin
                idx = idx - MASTERS;
            end
            if (i_psel[idx]) begin
                w_winner = IDX_W'(idx);
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= ST_IDLE;
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_grant   <= '0;
            r_last    <= IDX_W'(MASTERS - 1);
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_grant <= w_winner;
                        r_state <= ST_SETUP;
                        r_psel  <= 1'b1;
                    end
                end
                ST_SETUP: begin
                    r_state   <= ST_ACCESS;
                    r_penable <= 1'b1;
                end
                ST_ACCESS: begin
                    if (i_pready) begin
                        r_last    <= r_grant;
                        r_state   <= ST_IDLE;
                        r_psel    <= 1'b0;
                        r_penable <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_psel    <= 1'b0;
                    r_penable <= 1'b0;
                end
            endcase
        end
    end

    assign o_psel    = r_psel;
    assign o_penable = r_penable;
    assign o_prdata  = i_prdata;

    // Address/data mux; requester 0 is the default so the shared port
    // follows requester 0 out of reset.
    always_comb begin
        o_paddr  = i_paddr[0 +: ADDRESS_WIDTH];
        o_pwrite = i_pwrite[0];
        o_pwdata = i_pwdata[0 +: BUS_WIDTH];
        o_pstrb  = i_pstrb[0 +: STRB_W];
        for (int i = 1; i < MASTERS; i++) begin
            if (r_grant == IDX_W'(i)) begin
                o_paddr  = i_paddr[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
                o_pwrite = i_pwrite[i];
                o_pwdata = i_pwdata[i*BUS_WIDTH +: BUS_WIDTH];
                o_pstrb  = i_pstrb[i*STRB_W +: STRB_W];
            end
        end
    end

    // Completion is steered combinationally so the requester sees pready in
    // the same cycle the completer gives it.
    assign w_complete = (r_state == ST_ACCESS) && i_pready;

    generate
        for (genvar gi = 0; gi < MASTERS; gi++) begin : g_resp
            assign o_pready[gi]  = w_complete && (r_grant == IDX_W'(gi));
            assign o_pslverr[gi] = w_complete && (r_grant == IDX_W'(gi)) && i_pslverr;
        end
    endgenerate

endmodule

// File: tb/tb_rggen_apb_arbiter.sv
// -----------------------------------------------------------------------------
// Bench for rggen_apb_arbiter: a 2-requester and a 3-requester instance share
// the same stimulus (the 2-requester one sees only the low requesters).  A
// transaction-level model per instance predicts every output each cycle;
// directed scenarios add fixed expectations on top.
// -----------------------------------------------------------------------------
module tb_rggen_apb_arbiter;
    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [2:0]  psel;
    logic [2:0]  pwrite;
    logic [23:0] paddr;
    logic [95:0] pwdata;
    logic [11:0] pstrb;
    logic        c_pready;
    logic        c_pslverr;
    logic [31:0] c_prdata;

    logic [1:0]  o2_pready, o2_pslverr;
    logic [31:0] o2_prdata, o2_pwdata;
    logic        o2_psel, o2_penable, o2_pwrite;
    logic [7:0]  o2_paddr;
    logic [3:0]  o2_pstrb;

    logic [2:0]  o3_pready, o3_pslverr;
    logic [31:0] o3_prdata, o3_pwdata;
    logic        o3_psel, o3_penable, o3_pwrite;
    logic [7:0]  o3_paddr;
    logic [3:0]  o3_pstrb;

    rggen_apb_arbiter #(.ADDRESS_WIDTH(8), .BUS_WIDTH(32), .MASTERS(2)) dut2 (
        .i_clk(clk), .i_rst(rst),
        .i_psel(psel[1:0]), .i_paddr(paddr[15:0]), .i_pwrite(pwrite[1:0]),
        .i_pwdata(pwdata[63:0]), .i_pstrb(pstrb[7:0]),
        .o_pready(o2_pready), .o_prdata(o2_prdata), .o_pslverr(o2_pslverr),
        .o_psel(o2_psel), .o_penable(o2_penable), .o_paddr(o2_paddr),
        .o_pwrite(o2_pwrite), .o_pwdata(o2_pwdata), .o_pstrb(o2_pstrb),
        .i_pready(c_pready), .i_prdata(c_prdata), .i_pslverr(c_pslverr)
    );

    rggen_apb_arbiter #(.ADDRESS_WIDTH(8), .BUS_WIDTH(32), .MASTERS(3)) dut3 (
        .i_clk(clk), .i_rst(rst),
        .i_psel(psel), .i_paddr(paddr), .i_pwrite(pwrite),
        .i_pwdata(pwdata), .i_pstrb(pstrb),
        .o_pready(o3_pready), .o_prdata(o3_prdata), .o_pslverr(o3_pslverr),
        .o_psel(o3_psel), .o_penable(o3_penable), .o_paddr(o3_paddr),
        .o_pwrite(o3_pwrite), .o_pwdata(o3_pwdata), .o_pstrb(o3_pstrb),
        .i_pready(c_pready), .i_prdata(c_prdata), .i_pslverr(c_pslverr)
    );

    int checks = 0;
    int errors = 0;

    // Transaction model per instance: is a transfer in flight, who owns it,
    // how many cycles it has been on the bus, and who was served last.
    int mm[2]      = '{2, 3};
    int m_busy[2];
    int m_age[2];
    int m_owner[2];
    int m_last[2];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_busy[d]  = 0;
            m_age[d]   = 0;
            m_owner[d] = 0;
            m_last[d]  = mm[d] - 1;
        end
    endtask

    // Advance the model by one clock using the inputs sampled at the edge.
    task automatic model_step();
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                m_busy[d]  = 0;
                m_age[d]   = 0;
                m_owner[d] = 0;
                m_last[d]  = mm[d] - 1;
            end else if (m_busy[d] == 0) begin
                // Walk the ring from the requester after the last one served.
                for (int k = 1; k <= mm[d]; k++) begin
                    int j;
                    j = (m_last[d] + k) % mm[d];
                    if (psel[j] && m_busy[d] == 0) begin
                        m_owner[d] = j;
                        m_busy[d]  = 1;
                        m_age[d]   = 0;
                    end
                end
            end else if (m_age[d] == 0) begin
                m_age[d] = 1;
            end else if (c_pready) begin
                m_busy[d] = 0;
                m_last[d] = m_owner[d];
            end
        end
    endtask

    task automatic check_one(input string pfx, input int d,
                             input logic o_sel, input logic o_en,
                             input logic [2:0] o_rdy, input logic [2:0] o_err,
                             input logic [31:0] o_rd, input logic [7:0] o_ad,
                             input logic o_wr, input logic [31:0] o_wd,
                             input logic [3:0] o_st);
        int   own;
        logic done;
        logic [2:0] e_rdy;
        logic [2:0] e_err;
        own   = m_owner[d];
        done  = (m_busy[d] != 0) && (m_age[d] > 0) && c_pready;
        e_rdy = done ? 3'(1 << own) : 3'b000;
        e_err = (done && c_pslverr) ? 3'(1 << own) : 3'b000;
        chk({pfx, " psel"},    64'(o_sel), 64'(m_busy[d] != 0));
        chk({pfx, " penable"}, 64'(o_en),  64'((m_busy[d] != 0) && (m_age[d] > 0)));
        chk({pfx, " pready"},  64'(o_rdy), 64'(e_rdy));
        chk({pfx, " pslverr"}, 64'(o_err), 64'(e_err));
        chk({pfx, " prdata"},  64'(o_rd),  64'(c_prdata));
        chk({pfx, " paddr"},   64'(o_ad),  64'(paddr[own*8 +: 8]));
        chk({pfx, " pwrite"},  64'(o_wr),  64'(pwrite[own]));
        chk({pfx, " pwdata"},  64'(o_wd),  64'(pwdata[own*32 +: 32]));
        chk({pfx, " pstrb"},   64'(o_st),  64'(pstrb[own*4 +: 4]));
        if (done) begin
            $display("m%0d xfer: requester %0d addr=%02h write=%0b slverr=%0b",
                     mm[d], own, paddr[own*8 +: 8], pwrite[own], c_pslverr);
        end
    endtask

    // One clock: check all outputs against the model, then advance it.
    task automatic tick();
        #1;
        check_one("m2", 0, o2_psel, o2_penable, {1'b0, o2_pready}, {1'b0, o2_pslverr},
                  o2_prdata, o2_paddr, o2_pwrite, o2_pwdata, o2_pstrb);
        check_one("m3", 1, o3_psel, o3_penable, o3_pready, o3_pslverr,
                  o3_prdata, o3_paddr, o3_pwrite, o3_pwdata, o3_pstrb);
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic set_req(input int i, input logic [7:0] a, input logic [31:0] wd,
                           input logic wr, input logic [3:0] st);
        paddr[i*8 +: 8]   = a;
        pwdata[i*32 +: 32] = wd;
        pwrite[i]         = wr;
        pstrb[i*4 +: 4]   = st;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        psel = 3'b000;
        tick();
        rst = 1'b0;
    endtask

    logic [1:0] grants[$];

    initial begin
        rst = 1'b1; psel = '0; pwrite = '0; paddr = '0; pwdata = '0; pstrb = '0;
        c_pready = 1'b0; c_pslverr = 1'b0; c_prdata = '0;
        model_reset();
        @(negedge clk);

        // Power-up reset with no requests.
        tick();
        tick();
        chk("reset psel", 64'(o2_psel), 64'd0);
        chk("reset penable", 64'(o2_penable), 64'd0);
        chk("reset pready", 64'(o2_pready), 64'd0);
        rst = 1'b0;
        tick();

        // Single write from requester 1 with zero wait states.
        set_req(1, 8'h10, 32'hDEADBEEF, 1'b1, 4'hF);
        psel = 3'b010;
        c_pready = 1'b1;
        tick();
        #1;
        chk("sw psel c1", 64'(o2_psel), 64'd1);
        chk("sw penable c1", 64'(o2_penable), 64'd0);
        tick();
        #1;
        chk("sw penable c2", 64'(o2_penable), 64'd1);
        chk("sw paddr c2", 64'(o2_paddr), 64'h10);
        chk("sw pready c2", 64'(o2_pready), 64'b10);
        tick();
        psel = 3'b000;
        tick();

        // Contention between requesters 0 and 1.
        do_reset();
        set_req(0, 8'h04, 32'h0000_1111, 1'b1, 4'h3);
        set_req(1, 8'h08, 32'h2222_0000, 1'b0, 4'hC);
        psel = 3'b011;
        c_pready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (o2_pready == 2'b01) grants.push_back(2'd0);
            if (o2_pready == 2'b10) grants.push_back(2'd1);
            tick();
        end
        psel = 3'b000;
        chk("cont count", 64'(grants.size()), 64'd4);
        for (int g = 0; g < 4 && g < grants.size(); g++) begin
            chk($sformatf("cont grant%0d", g), 64'(grants[g]), 64'(g % 2));
        end
        tick();

        // Wait states followed by an error completion.
        set_req(0, 8'h20, 32'h0, 1'b0, 4'h0);
        psel = 3'b001;
        c_pready = 1'b0;
        tick();
        tick();
        tick();
        tick();
        #1;
        chk("ws penable c4", 64'(o2_penable), 64'd1);
        chk("ws pready c4", 64'(o2_pready), 64'd0);
        tick();
        c_pready = 1'b1; c_pslverr = 1'b1; c_prdata = 32'h1234;
        #1;
        chk("ws pready c5", 64'(o2_pready), 64'b01);
        chk("ws pslverr c5", 64'(o2_pslverr), 64'b01);
        chk("ws prdata c5", 64'(o2_prdata), 64'h1234);
        tick();
        psel = 3'b000; c_pslverr = 1'b0;
        tick();

        // Reset in the middle of an ACCESS phase with the completer stalling.
        psel = 3'b010;
        c_pready = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        model_reset();
        #1;
        chk("mid psel", 64'(o2_psel), 64'd0);
        chk("mid penable", 64'(o2_penable), 64'd0);
        chk("mid pready", 64'(o2_pready), 64'd0);
        tick();
        rst = 1'b0;
        psel = 3'b011;
        c_pready = 1'b1;
        tick();
        tick();
        #1;
        chk("mid first grant", 64'(o2_pready), 64'b01);
        tick();
        psel = 3'b000;
        tick();

        // Three requesters: after requester 0, requester 2 beats 0.
        do_reset();
        set_req(2, 8'h30, 32'hCAFE_0002, 1'b1, 4'h1);
        psel = 3'b001;
        c_pready = 1'b1;
        tick();
        tick();
        #1;
        chk("m3 first", 64'(o3_pready), 64'b001);
        tick();
        psel = 3'b101;
        tick();
        tick();
        #1;
        chk("m3 second", 64'(o3_pready), 64'b100);
        tick();
        tick();
        tick();
        #1;
        chk("m3 third", 64'(o3_pready), 64'b001);
        tick();
        psel = 3'b000;
        tick();

        // Randomised traffic against the model.
        for (int c = 0; c < 600; c++) begin
            rst       = ($urandom_range(0, 149) == 0);
            if (rst) model_reset();
            psel      = 3'($urandom_range(0, 7));
            pwrite    = 3'($urandom);
            paddr     = 24'($urandom);
            pwdata    = {$urandom, $urandom, $urandom};
            pstrb     = 12'($urandom);
            c_pready  = ($urandom_range(0, 2) != 0);
            c_pslverr = ($urandom_range(0, 3) == 0);
            c_prdata  = $urandom;
            tick();
        end
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
